// File: rtl/delay_tap_line_if.sv
// delay_tap_line_if
//   Groups the data and tap-change handshake signals of delay_tap_line.
//   master : drives A, TAP, LOAD; observes Z, BUSY, ACK, SAT
//   slave  : the delay line itself
// Signals:
//   A     data to delay
//   TAP   requested tap index (sampled when LOAD is accepted)
//   LOAD  one-cycle tap-change request
//   Z     delayed data (registered)
//   BUSY  tap change in progress
//   ACK   one-cycle pulse when the new tap takes effect
//   SAT   valid with ACK; requested tap was clamped
interface delay_tap_line_if #(
    parameter int TAPW = 4
);
    logic            A;
    logic [TAPW-1:0] TAP;
    logic            LOAD;
    logic            Z;
    logic            BUSY;
    logic            ACK;
    logic            SAT;

    modport master (
        output A, TAP, LOAD,
        input  Z, BUSY, ACK, SAT
    );

    modport slave (
        input  A, TAP, LOAD,
        output Z, BUSY, ACK, SAT
    );
endinterface

// File: rtl/delay_tap_line.sv
// delay_tap_line
//   Programmable single-bit delay line feeding the DELAY primitive. A is
//   shifted through DEPTH stages every cycle; Z is the registered stage
//   selected by the current tap. Tap changes use a LOAD/ACK handshake:
//   Z is frozen for HOLD_CYC cycles, then the new tap is applied in one
//   APPLY cycle, so Z never glitches during the switch.
// Ports:
//   CLK   rising-edge clock
//   RSTN  asynchronous active-low reset
//   bus   delay_tap_line_if.slave (A, TAP, LOAD in; Z, BUSY, ACK, SAT out)
// Parameters:
//   DEPTH     number of shift stages (max tap DEPTH-1)
//   TAPW      width of TAP, 2**TAPW >= DEPTH
//   HOLD_CYC  cycles Z stays frozen during a change, 1..15
// Build option:
//   DELAY_TAP_MAJFILT_EN  adds a 3-sample majority filter after the tap mux
//                         (latency cur_tap+3, isolated 1-cycle pulses removed)
module delay_tap_line #(
    parameter int DEPTH    = 16,
    parameter int TAPW     = 4,
    parameter int HOLD_CYC = 2
) (
    input  logic             CLK,
    input  logic             RSTN,
    delay_tap_line_if.slave  bus
);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = 4;
    localparam logic [TAPW-1:0] MAX_TAP_REQ = TAPW'(DEPTH - 1);
    localparam logic [IDXW-1:0] MAX_TAP     = IDXW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t          state_reg;
    logic [DEPTH-1:0] sr_reg;
    logic [DEPTH-1:0] sr_next;
    logic [IDXW-1:0] cur_tap_reg;
    logic [IDXW-1:0] new_tap_reg;
    logic            sat_q_reg;
    logic [CNTW-1:0] cnt_reg;
    logic            busy_reg;
    logic            ack_reg;
    logic            sat_reg;
    logic            z_reg;

    // Clamp the request to the deepest stage.
    logic            req_sat;
    logic [IDXW-1:0] req_tap;
    assign req_sat = (bus.TAP > MAX_TAP_REQ);
    assign req_tap = req_sat ? MAX_TAP : bus.TAP[IDXW-1:0];

    // Shift chain: stage 0 takes A, each later stage takes its predecessor.
    assign sr_next[0] = bus.A;
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign sr_next[gi] = sr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= sr_next;
        end
    end

    // In APPLY the mux already looks at the new tap, so the first Z from
    // the new tap lands on the same edge that commits cur_tap.
    logic [IDXW-1:0] tap_sel;
    logic            tap_bit;
    assign tap_sel = (state_reg == ST_APPLY) ? new_tap_reg : cur_tap_reg;
    assign tap_bit = sr_reg[tap_sel];

    // Tap-change sequencer with registered handshake outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg   <= ST_IDLE;
            cur_tap_reg <= '0;
            new_tap_reg <= '0;
            sat_q_reg   <= 1'b0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            ack_reg     <= 1'b0;
            sat_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.LOAD) begin
                        new_tap_reg <= req_tap;
                        sat_q_reg   <= req_sat;
                        cnt_reg     <= CNTW'(HOLD_CYC - 1);
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // LOAD is ignored here; the request in flight is final.
                    if (cnt_reg == '0) begin
                        ack_reg   <= 1'b1;
                        sat_reg   <= sat_q_reg;
                        state_reg <= ST_APPLY;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_APPLY: begin
                    cur_tap_reg <= new_tap_reg;
                    ack_reg     <= 1'b0;
                    sat_reg     <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                    ack_reg   <= 1'b0;
                    sat_reg   <= 1'b0;
                end
            endcase
        end
    end

`ifdef DELAY_TAP_MAJFILT_EN
    // Majority filter: the whole output pipeline freezes in HOLD so the
    // filter history stays coherent across the tap switch.
    logic m0_reg;
    logic m1_reg;
    logic m2_reg;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m0_reg <= 1'b0;
            m1_reg <= 1'b0;
            m2_reg <= 1'b0;
            z_reg  <= 1'b0;
        end else if (state_reg != ST_HOLD) begin
            m0_reg <= tap_bit;
            m1_reg <= m0_reg;
            m2_reg <= m1_reg;
            z_reg  <= (m0_reg & m1_reg) | (m0_reg & m2_reg) | (m1_reg & m2_reg);
        end
    end
`else
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            z_reg <= 1'b0;
        end else if (state_reg != ST_HOLD) begin
            z_reg <= tap_bit;
        end
    end
`endif

    assign bus.Z    = z_reg;
    assign bus.BUSY = busy_reg;
    assign bus.ACK  = ack_reg;
    assign bus.SAT  = sat_reg;

endmodule
